// File: rtl/tx_phase_sequencer.sv
// Oversampling phase sequencer: polyphase index plus one-cycle symbol strobe for the TX filter chain.
// Registered outputs; factor/strobe phase are clamped and latched only at start, symbol wrap (RUN) or sync.
module tx_phase_sequencer #(
  parameter int OS_MAX = 8,
  parameter int PH_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_sync,
  input  logic [PH_W:0]     i_os_factor,
  input  logic [PH_W-1:0]   i_strobe_phase,
  output logic [PH_W-1:0]   o_phase,
  output logic              o_sym_strobe,
  output logic [CNT_W-1:0]  o_sym_count,
  output logic              o_running,
  output logic              o_cfg_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [PH_W:0]    L_OS_MAX = (PH_W+1)'(OS_MAX);
  localparam logic [PH_W:0]    L_ONE_F  = (PH_W+1)'(1);
  localparam logic [PH_W-1:0]  L_ONE_P  = PH_W'(1);
  localparam logic [CNT_W-1:0] L_ONE_C  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [PH_W-1:0]  r_phase;
  logic [PH_W:0]    r_factor;
  logic [PH_W-1:0]  r_strobe_ph;
  logic             r_strobe;
  logic [CNT_W-1:0] r_count;
  logic             r_running;
  logic             r_cfg_err;

  logic [PH_W:0]    w_ld_factor;
  logic [PH_W-1:0]  w_ld_sph;
  logic             w_ld_clamp;
  logic             w_wrap;
  logic [PH_W-1:0]  w_ph_inc;
  logic [1:0]       w_nxt_state;
  logic [PH_W-1:0]  w_nxt_phase;
  logic             w_nxt_running;
  logic             w_load;
  logic             w_step;
  logic [PH_W-1:0]  w_sph_eff;
  logic             w_nxt_strobe;

  // Strobe phase is clamped against the already-clamped factor.
  always_comb begin
    w_ld_factor = i_os_factor;
    w_ld_clamp  = 1'b0;
    if (i_os_factor == '0) begin
      w_ld_factor = L_ONE_F;
      w_ld_clamp  = 1'b1;
    end else if (i_os_factor > L_OS_MAX) begin
      w_ld_factor = L_OS_MAX;
      w_ld_clamp  = 1'b1;
    end
    w_ld_sph = i_strobe_phase;
    if ({1'b0, i_strobe_phase} >= w_ld_factor) begin
      w_ld_sph   = PH_W'(w_ld_factor - L_ONE_F);
      w_ld_clamp = 1'b1;
    end
  end

  assign w_wrap   = ({1'b0, r_phase} == (r_factor - L_ONE_F));
  assign w_ph_inc = r_phase + L_ONE_P;

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_phase   = r_phase;
    w_nxt_running = r_running;
    w_load        = 1'b0;
    w_step        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enable && i_start) begin
          w_load        = 1'b1;
          w_step        = 1'b1;
          w_nxt_state   = S_RUN;
          w_nxt_phase   = '0;
          w_nxt_running = 1'b1;
        end
      end
      S_RUN: begin
        // Sync ignores i_enable and wins over a simultaneous stop.
        if (i_sync) begin
          w_load      = 1'b1;
          w_step      = 1'b1;
          w_nxt_phase = '0;
        end else if (i_enable) begin
          w_step = 1'b1;
          if (i_stop) w_nxt_state = S_DRAIN;
          if (w_wrap) begin
            w_nxt_phase = '0;
            w_load      = 1'b1;
          end else begin
            w_nxt_phase = w_ph_inc;
          end
        end
      end
      S_DRAIN: begin
        if (i_sync || (i_enable && w_wrap)) begin
          w_nxt_state   = S_IDLE;
          w_nxt_phase   = '0;
          w_nxt_running = 1'b0;
        end else if (i_enable) begin
          w_step      = 1'b1;
          w_nxt_phase = w_ph_inc;
        end
      end
      default: begin
        w_nxt_state   = S_IDLE;
        w_nxt_phase   = '0;
        w_nxt_running = 1'b0;
      end
    endcase
    w_sph_eff    = w_load ? w_ld_sph : r_strobe_ph;
    w_nxt_strobe = w_step && (w_nxt_phase == w_sph_eff);
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_factor    <= L_OS_MAX;
      r_strobe_ph <= '0;
      r_strobe    <= 1'b0;
      r_count     <= '0;
      r_running   <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_phase   <= w_nxt_phase;
      r_running <= w_nxt_running;
      r_strobe  <= w_nxt_strobe;
      if (w_load) begin
        r_factor    <= w_ld_factor;
        r_strobe_ph <= w_ld_sph;
        if (w_ld_clamp) r_cfg_err <= 1'b1;
      end
      if (w_nxt_strobe) r_count <= r_count + L_ONE_C;
    end
  end

  assign o_phase      = r_phase;
  assign o_sym_strobe = r_strobe;
  assign o_sym_count  = r_count;
  assign o_running    = r_running;
  assign o_cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_tx_phase_sequencer.sv
// Bench for tx_phase_sequencer: directed scenarios plus random traffic against a symbol-level model.
module tb_tx_phase_sequencer;

  logic        clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_sync = 1'b0;
  logic [3:0]  i_os_factor = 4'd4;
  logic [2:0]  i_strobe_phase = 3'd0;
  logic [2:0]  o_phase;
  logic        o_sym_strobe;
  logic [15:0] o_sym_count;
  logic        o_running;
  logic        o_cfg_err;

  int total = 0;
  int bad = 0;

  // Model: mode 0=idle 1=run 2=drain
  int m_mode = 0, m_ph = 0, m_f = 8, m_sp = 0, m_cnt = 0;
  bit m_stb = 0, m_err = 0;

  always #5 clock = ~clock;

  tx_phase_sequencer #(.OS_MAX(8), .PH_W(3), .CNT_W(16)) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_start(i_start),
    .i_stop(i_stop), .i_sync(i_sync), .i_os_factor(i_os_factor),
    .i_strobe_phase(i_strobe_phase), .o_phase(o_phase), .o_sym_strobe(o_sym_strobe),
    .o_sym_count(o_sym_count), .o_running(o_running), .o_cfg_err(o_cfg_err)
  );

  wire [21:0] dut_vec = {o_phase, o_sym_strobe, o_sym_count, o_running, o_cfg_err};

  function automatic logic [21:0] exp_vec();
    return {3'(m_ph), m_stb, 16'(m_cnt), (m_mode != 0), m_err};
  endfunction

  task automatic m_load();
    int f = int'(i_os_factor);
    int s = int'(i_strobe_phase);
    if (f == 0) begin f = 1; m_err = 1; end
    else if (f > 8) begin f = 8; m_err = 1; end
    if (s >= f) begin s = f - 1; m_err = 1; end
    m_f = f;
    m_sp = s;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clock);
    m_stb = 0;
    if (i_reset) begin
      m_mode = 0; m_ph = 0; m_f = 8; m_sp = 0; m_cnt = 0; m_err = 0;
    end else begin
      case (m_mode)
        0: if (i_enable && i_start) begin
             m_load(); m_mode = 1; m_ph = 0; m_stb = (m_sp == 0);
           end
        1: if (i_sync) begin
             m_load(); m_ph = 0; m_stb = (m_sp == 0);
           end else if (i_enable) begin
             if (i_stop) m_mode = 2;
             m_ph = (m_ph + 1) % m_f;
             if (m_ph == 0) m_load();
             m_stb = (m_ph == m_sp);
           end
        default: if (i_sync) begin
             m_mode = 0; m_ph = 0;
           end else if (i_enable) begin
             m_ph = (m_ph + 1) % m_f;
             if (m_ph == 0) m_mode = 0;
             else m_stb = (m_ph == m_sp);
           end
      endcase
      if (m_stb) m_cnt = (m_cnt + 1) % 65536;
    end
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1; tick(); i_reset = 0;
  endtask

  task automatic test_reset();
    i_reset = 1; tick(); tick();
    total++; if (dut_vec !== 22'd0) begin bad++; $display("FAIL reset_values got=%h exp=%h", dut_vec, 22'd0); end
    total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec()); end
    i_reset = 0;
  endtask

  task automatic test_basic();
    i_os_factor = 4; i_strobe_phase = 0; i_enable = 1; i_start = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL basic_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec()); end
      total++; if ({o_phase, o_sym_strobe, o_sym_count, o_running} !== {3'(k % 4), (k % 4 == 0), 16'(k / 4 + 1), 1'b1}) begin
        bad++; $display("FAIL basic_seq k=%0d got ph=%0d stb=%0d cnt=%0d run=%0d exp ph=%0d cnt=%0d", k, o_phase, o_sym_strobe, o_sym_count, o_running, k % 4, k / 4 + 1);
      end
    end
    total++; if (o_sym_count !== 16'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", o_sym_count); end
  endtask

  task automatic test_factor_change();
    int exp_ph [15] = '{2, 3, 0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0};
    tick(); tick();
    total++; if (o_phase !== 3'd1) begin bad++; $display("FAIL fchg_pre got=%0d exp=1", o_phase); end
    i_os_factor = 6;
    for (int k = 0; k < 15; k++) begin
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL fchg_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec()); end
      total++; if ({o_phase, o_sym_strobe} !== {3'(exp_ph[k]), (exp_ph[k] == 0)}) begin
        bad++; $display("FAIL fchg_seq k=%0d got ph=%0d stb=%0d exp ph=%0d", k, o_phase, o_sym_strobe, exp_ph[k]);
      end
    end
  endtask

  task automatic test_enable_gap();
    int seen = 0;
    do_reset();
    i_os_factor = 3; i_strobe_phase = 2; i_enable = 1; i_start = 1;
    tick(); tick(); tick();
    total++; if ({o_phase, o_sym_strobe, o_sym_count} !== {3'd2, 1'b1, 16'd1}) begin bad++; $display("FAIL gap_pre got=%h exp=%h", {o_phase, o_sym_strobe, o_sym_count}, {3'd2, 1'b1, 16'd1}); end
    seen += o_sym_strobe;
    i_enable = 0;
    for (int k = 0; k < 2; k++) begin
      tick(); seen += o_sym_strobe;
      total++; if ({o_phase, o_sym_strobe, o_sym_count, o_running} !== {3'd2, 1'b0, 16'd1, 1'b1}) begin
        bad++; $display("FAIL gap_hold k=%0d got ph=%0d stb=%0d cnt=%0d", k, o_phase, o_sym_strobe, o_sym_count);
      end
    end
    i_enable = 1; tick(); seen += o_sym_strobe;
    total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL gap_model got=%h exp=%h", dut_vec, exp_vec()); end
    total++; if (seen !== 1 || o_phase !== 3'd0) begin bad++; $display("FAIL gap_once got strobes=%0d ph=%0d exp strobes=1 ph=0", seen, o_phase); end
  endtask

  task automatic test_stop();
    do_reset();
    i_os_factor = 4; i_strobe_phase = 0; i_enable = 1; i_start = 1;
    tick(); tick();
    i_start = 0; i_stop = 1; tick(); i_stop = 0;
    total++; if ({o_phase, o_running} !== {3'd2, 1'b1}) begin bad++; $display("FAIL stop_drain2 got ph=%0d run=%0d exp ph=2 run=1", o_phase, o_running); end
    tick();
    total++; if ({o_phase, o_running} !== {3'd3, 1'b1}) begin bad++; $display("FAIL stop_drain3 got ph=%0d run=%0d exp ph=3 run=1", o_phase, o_running); end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if ({o_phase, o_sym_strobe, o_sym_count, o_running} !== {3'd0, 1'b0, 16'd1, 1'b0}) begin
        bad++; $display("FAIL stop_idle k=%0d got ph=%0d stb=%0d cnt=%0d run=%0d", k, o_phase, o_sym_strobe, o_sym_count, o_running);
      end
    end
    i_start = 1; tick(); i_start = 0; tick();
    i_stop = 1; tick(); i_stop = 0;
    i_sync = 1; tick(); i_sync = 0;
    total++; if ({o_phase, o_sym_strobe, o_running} !== 5'b0) begin bad++; $display("FAIL drain_sync got ph=%0d stb=%0d run=%0d exp 0", o_phase, o_sym_strobe, o_running); end
    tick();
    total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL drain_sync_model got=%h exp=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_illegal();
    do_reset();
    i_os_factor = 0; i_strobe_phase = 0; i_enable = 1; i_start = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if ({o_phase, o_sym_strobe, o_cfg_err} !== {3'd0, 1'b1, 1'b1}) begin bad++; $display("FAIL ill_f1 k=%0d got ph=%0d stb=%0d err=%0d", k, o_phase, o_sym_strobe, o_cfg_err); end
    end
    i_os_factor = 12; tick();
    i_os_factor = 4; i_strobe_phase = 5;
    for (int k = 1; k < 8; k++) begin
      tick();
      total++; if ({o_phase, o_sym_strobe} !== {3'(k), 1'b0}) begin bad++; $display("FAIL ill_f8 k=%0d got ph=%0d stb=%0d", k, o_phase, o_sym_strobe); end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if ({o_phase, o_sym_strobe, o_cfg_err} !== {3'(k), (k == 3), 1'b1}) begin bad++; $display("FAIL ill_sp k=%0d got ph=%0d stb=%0d err=%0d", k, o_phase, o_sym_strobe, o_cfg_err); end
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL ill_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec()); end
    end
    i_start = 0; do_reset();
    total++; if (o_cfg_err !== 1'b0) begin bad++; $display("FAIL ill_reset got=%0d exp=0", o_cfg_err); end
  endtask

  task automatic test_reset_mid();
    i_os_factor = 4; i_strobe_phase = 0; i_enable = 1; i_start = 1;
    tick(); tick(); tick();
    total++; if (o_phase !== 3'd2) begin bad++; $display("FAIL rmid_pre got=%0d exp=2", o_phase); end
    i_reset = 1; tick(); i_reset = 0; i_start = 0;
    total++; if (dut_vec !== 22'd0) begin bad++; $display("FAIL rmid_vals got=%h exp=0", dut_vec); end
    tick();
    total++; if (dut_vec !== 22'd0) begin bad++; $display("FAIL rmid_idle got=%h exp=0", dut_vec); end
  endtask

  task automatic test_count_wrap();
    do_reset();
    i_os_factor = 1; i_strobe_phase = 0; i_enable = 1; i_start = 1;
    for (int k = 0; k < 65535; k++) tick();
    total++; if ({o_sym_count, o_sym_strobe} !== {16'hFFFF, 1'b1}) begin bad++; $display("FAIL wrap_max got=%h exp=ffff", o_sym_count); end
    tick();
    total++; if ({o_sym_count, o_sym_strobe} !== {16'h0000, 1'b1}) begin bad++; $display("FAIL wrap_zero got=%h exp=0", o_sym_count); end
    total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL wrap_model got=%h exp=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      i_reset        = ($urandom_range(0, 199) == 0);
      i_enable       = ($urandom_range(0, 3) != 0);
      i_start        = ($urandom_range(0, 2) != 0);
      i_stop         = ($urandom_range(0, 7) == 0);
      i_sync         = ($urandom_range(0, 15) == 0);
      i_os_factor    = 4'($urandom_range(0, 15));
      i_strobe_phase = 3'($urandom_range(0, 7));
      tick();
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec, exp_vec()); end
    end
    i_reset = 0; i_stop = 0; i_sync = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_factor_change();
    test_enable_gap();
    test_stop();
    test_illegal();
    test_reset_mid();
    test_count_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
